// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction fetch front end: owns the PC, issues in-order word requests to
// instruction memory and buffers returned words with their PCs for decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        iClk,
  input  logic        iRstN,
  output logic        oImemReqValid,
  output logic [31:0] oImemAddr,
  input  logic        iImemReqReady,
  input  logic        iImemRespValid,
  input  logic [31:0] iImemRespData,
  input  logic        iRedirectValid,
  input  logic [31:0] iRedirectPC,
  output logic        oDecValid,
  output logic [31:0] oDecInstruction,
  output logic [31:0] oDecPC,
  input  logic        iDecReady
);

  localparam int              CW       = $clog2(DEPTH + 1);
  localparam int              PW       = $clog2(DEPTH);
  localparam logic [CW:0]     CREDITS  = (CW + 1)'(DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
  localparam logic [31:0]     NOP      = 32'h0000_0013;

  logic [31:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] dropCnt;
  logic [CW-1:0] occupancy;

  // PCs of live (non-stale) in-flight requests, oldest first
  logic [31:0]   pcFifo [DEPTH];
  logic [PW-1:0] pcWrPtr;
  logic [PW-1:0] pcRdPtr;

  logic [31:0]   entryPc    [DEPTH];
  logic [31:0]   entryInstr [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;

  logic [CW:0]   creditsUsed;
  logic          reqFire;
  logic          respLive;
  logic          respKeep;
  logic          respDrop;
  logic          popFire;

  // The low redirect bits are architecturally ignored
  logic          unusedRedirectLsbs;
  assign unusedRedirectLsbs = ^iRedirectPC[1:0];

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    creditsUsed     = {1'b0, inflight} + {1'b0, occupancy};
    oImemReqValid   = iRstN && !iRedirectValid && (creditsUsed < CREDITS);
    oImemAddr       = pc;
    oDecValid       = !iRedirectValid && (occupancy != '0);
    oDecInstruction = oDecValid ? entryInstr[rdPtr] : NOP;
    oDecPC          = oDecValid ? entryPc[rdPtr] : 32'h0000_0000;
    reqFire         = oImemReqValid && iImemReqReady;
    respLive        = iImemRespValid && (inflight != '0);
    respDrop        = respLive && !iRedirectValid && (dropCnt != '0);
    respKeep        = respLive && !iRedirectValid && (dropCnt == '0);
    popFire         = oDecValid && iDecReady;
  end

  // A redirect discards every outstanding request, including one returning now
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      pc        <= RESET_PC;
      inflight  <= '0;
      dropCnt   <= '0;
      occupancy <= '0;
      pcWrPtr   <= '0;
      pcRdPtr   <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
    end else if (iRedirectValid) begin
      pc        <= {iRedirectPC[31:2], 2'b00};
      inflight  <= inflight - CW'(respLive);
      dropCnt   <= inflight - CW'(respLive);
      occupancy <= '0;
      pcWrPtr   <= '0;
      pcRdPtr   <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
    end else begin
      if (reqFire) begin
        pc      <= pc + 32'd4;
        pcWrPtr <= nextPtr(pcWrPtr);
      end
      if (respKeep) begin
        pcRdPtr <= nextPtr(pcRdPtr);
        wrPtr   <= nextPtr(wrPtr);
      end
      if (popFire) begin
        rdPtr <= nextPtr(rdPtr);
      end
      inflight  <= inflight + CW'(reqFire) - CW'(respLive);
      dropCnt   <= dropCnt - CW'(respDrop);
      occupancy <= occupancy + CW'(respKeep) - CW'(popFire);
    end
  end

  always_ff @(posedge iClk) begin
    if (reqFire) begin
      pcFifo[pcWrPtr] <= pc;
    end
    if (respKeep) begin
      entryPc[wrPtr]    <= pcFifo[pcRdPtr];
      entryInstr[wrPtr] <= iImemRespData;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// memory latency, handshakes and redirects against a queue-based model.
module tb_fetch_stage;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        iClk;
  logic        iRstN;
  logic        oImemReqValid;
  logic [31:0] oImemAddr;
  logic        iImemReqReady;
  logic        iImemRespValid;
  logic [31:0] iImemRespData;
  logic        iRedirectValid;
  logic [31:0] iRedirectPC;
  logic        oDecValid;
  logic [31:0] oDecInstruction;
  logic [31:0] oDecPC;
  logic        iDecReady;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .iClk(iClk), .iRstN(iRstN),
    .oImemReqValid(oImemReqValid), .oImemAddr(oImemAddr), .iImemReqReady(iImemReqReady),
    .iImemRespValid(iImemRespValid), .iImemRespData(iImemRespData),
    .iRedirectValid(iRedirectValid), .iRedirectPC(iRedirectPC),
    .oDecValid(oDecValid), .oDecInstruction(oDecInstruction), .oDecPC(oDecPC),
    .iDecReady(iDecReady)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct { logic [31:0] addr; logic [31:0] mpc; int epoch; int readyAt; } memReq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  typedef struct { int cyc; logic [31:0] val; } logRec_t;

  memReq_t     memQ[$];
  entry_t      kept[$];
  logRec_t     reqLog[$];
  logRec_t     decLog[$];
  int          nChecks = 0;
  int          nFail = 0;
  int          cycleNum = 0;
  int          phaseStart = 0;
  int          epoch = 0;
  logic [31:0] reqPc;
  int          readyPct, decPct, latMin, latMax;
  bit          spurious;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[31:16]} + 32'h0BAD_0001;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cycleNum, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    check32(name, {31'b0, act}, {31'b0, exp});
  endtask

  task automatic applyStimulus(input bit redir, input logic [31:0] tgt);
    iRedirectValid = redir;
    iRedirectPC    = tgt;
    iImemReqReady  = (int'($urandom_range(99)) < readyPct);
    iDecReady      = (int'($urandom_range(99)) < decPct);
    if (memQ.size() > 0 && memQ[0].readyAt <= cycleNum) begin
      iImemRespValid = 1'b1;
      iImemRespData  = memWord(memQ[0].addr);
    end else if (memQ.size() == 0 && spurious && $urandom_range(99) < 5) begin
      iImemRespValid = 1'b1;
      iImemRespData  = $urandom;
    end else begin
      iImemRespValid = 1'b0;
      iImemRespData  = $urandom;
    end
  endtask

  // Model: outstanding requests tagged with the redirect epoch they were issued in
  task automatic checkOutput;
    bit      r, mReq, mDec;
    memReq_t m;
    r    = iRedirectValid;
    mReq = !r && (memQ.size() + kept.size() < DEPTH);
    mDec = !r && (kept.size() > 0);
    check1("req_valid", oImemReqValid, mReq);
    if (mReq) check32("req_addr", oImemAddr, reqPc);
    check1("dec_valid", oDecValid, mDec);
    if (mDec) begin
      check32("dec_pc", oDecPC, kept[0].pc);
      check32("dec_instr", oDecInstruction, kept[0].instr);
    end else begin
      check32("idle_instr", oDecInstruction, NOP);
      check32("idle_pc", oDecPC, 32'h0);
    end
    if (oDecValid && iDecReady) begin
      decLog.push_back('{cycleNum - phaseStart, oDecPC});
      if (kept.size() > 0) void'(kept.pop_front());
    end
    if (iImemRespValid && memQ.size() > 0) begin
      m = memQ.pop_front();
      if (!r && m.epoch == epoch) kept.push_back('{m.mpc, memWord(m.mpc)});
    end
    if (oImemReqValid && iImemReqReady) begin
      memQ.push_back('{oImemAddr, reqPc, epoch,
                       cycleNum + int'($urandom_range(latMax, latMin))});
      reqLog.push_back('{cycleNum - phaseStart, oImemAddr});
      reqPc = reqPc + 32'd4;
    end
    if (r) begin
      kept.delete();
      epoch++;
      reqPc = {iRedirectPC[31:2], 2'b00};
    end
    check1("credit_bound", (memQ.size() + kept.size() <= DEPTH), 1'b1);
    cycleNum++;
  endtask

  task automatic runCycle(input bit redir, input logic [31:0] tgt);
    applyStimulus(redir, tgt);
    #1;
    checkOutput();
    @(negedge iClk);
  endtask

  task automatic doReset;
    iRstN          = 1'b0;
    iRedirectValid = 1'b0;
    iImemRespValid = 1'b0;
    iImemReqReady  = 1'b0;
    iDecReady      = 1'b0;
    #1;
    check1("rst_req_valid", oImemReqValid, 1'b0);
    check1("rst_dec_valid", oDecValid, 1'b0);
    check32("rst_dec_instr", oDecInstruction, NOP);
    check32("rst_dec_pc", oDecPC, 32'h0);
    check32("rst_addr", oImemAddr, RESET_PC);
    memQ.delete();
    kept.delete();
    reqPc = RESET_PC;
    epoch++;
    @(negedge iClk);
    @(negedge iClk);
    iRstN = 1'b1;
  endtask

  task automatic startPhase;
    phaseStart = cycleNum;
    reqLog.delete();
    decLog.delete();
  endtask

  initial begin
    iRstN = 1'b0; iRedirectValid = 1'b0; iRedirectPC = '0; iImemReqReady = 1'b0;
    iImemRespValid = 1'b0; iImemRespData = '0; iDecReady = 1'b0;
    readyPct = 100; decPct = 100; latMin = 1; latMax = 1; spurious = 1'b0;
    reqPc = RESET_PC;
    @(negedge iClk);

    // Streaming with 1-cycle memory: 2-cycle fetch-to-decode, 1 instr/cycle
    doReset();
    startPhase();
    repeat (12) runCycle(1'b0, 32'h0);
    check32("p1_req_count", reqLog.size(), 12);
    check32("p1_first_req_cyc", reqLog[0].cyc, 0);
    check32("p1_first_req_addr", reqLog[0].val, 32'h0);
    check32("p1_last_req_addr", reqLog[11].val, 32'h2C);
    check32("p1_dec_count", decLog.size(), 10);
    check32("p1_first_dec_cyc", decLog[0].cyc, 2);
    check32("p1_first_dec_pc", decLog[0].val, 32'h0);

    // Decode stalled: credits cap requests at DEPTH, each pop frees one a cycle later
    doReset();
    startPhase();
    decPct = 0;
    repeat (10) runCycle(1'b0, 32'h0);
    check32("p2_req_count", reqLog.size(), 4);
    check32("p2_req3_addr", reqLog[3].val, 32'hC);
    decPct = 100;
    repeat (10) runCycle(1'b0, 32'h0);
    check32("p2_dec0_pc", decLog[0].val, 32'h0);
    check32("p2_dec1_pc", decLog[1].val, 32'h4);
    check32("p2_dec2_pc", decLog[2].val, 32'h8);
    check32("p2_dec3_pc", decLog[3].val, 32'hC);
    check32("p2_dec0_cyc", decLog[0].cyc, 10);
    check32("p2_req4_cyc", reqLog[4].cyc, 11);
    check32("p2_req4_addr", reqLog[4].val, 32'h10);

    // Back-to-back redirects with stale responses still in flight
    doReset();
    startPhase();
    decPct = 0; latMin = 2; latMax = 2;
    repeat (2) runCycle(1'b0, 32'h0);
    latMin = 4; latMax = 4;
    runCycle(1'b0, 32'h0);
    runCycle(1'b1, 32'h0000_0103);
    startPhase();
    decPct = 100; latMin = 3; latMax = 3;
    runCycle(1'b0, 32'h0);
    runCycle(1'b1, 32'h0000_0200);
    latMin = 1; latMax = 1;
    repeat (10) runCycle(1'b0, 32'h0);
    check32("p3_first_req_addr", reqLog[0].val, 32'h100);
    check32("p3_second_req_addr", reqLog[1].val, 32'h200);
    check32("p3_first_dec_pc", decLog[0].val, 32'h200);

    // PC wraps modulo 2^32
    runCycle(1'b1, 32'hFFFF_FFF8);
    startPhase();
    repeat (8) runCycle(1'b0, 32'h0);
    check32("p4_req0", reqLog[0].val, 32'hFFFF_FFF8);
    check32("p4_req1", reqLog[1].val, 32'hFFFF_FFFC);
    check32("p4_req2", reqLog[2].val, 32'h0);
    check32("p4_dec0", decLog[0].val, 32'hFFFF_FFF8);
    check32("p4_dec1", decLog[1].val, 32'hFFFF_FFFC);
    check32("p4_dec2", decLog[2].val, 32'h0);

    // Randomized traffic with a reset in the middle
    doReset();
    startPhase();
    latMin = 1; latMax = 5; spurious = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) doReset();
      if (i % 250 == 0) begin
        readyPct = int'($urandom_range(100, 20));
        decPct   = int'($urandom_range(100, 10));
      end
      runCycle($urandom_range(99) < 3,
               ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15) : $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
